// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte sequencer: byte width, sequencer states
// and a counter-width helper.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        CAPTURE   = 3'd4,
        GAP       = 3'd5
    } seq_state_e;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Host byte streams plus the start/busy handshake towards the SPI master core.
interface spi_byte_sequencer_if;
    import spi_pkg::*;

    // tx_* and rx_* are valid/ready streams: a byte moves on every clock edge where
    // valid and ready are both high; valid must not wait on ready, and data is only
    // meaningful while valid is high. spi_start is a single-cycle pulse, spi_data_in
    // is held until the next start, spi_data_out is read when busy falls.
    logic                  tx_valid;
    logic                  tx_ready;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [SPI_BYTE_W-1:0] rx_data;
    logic                  spi_start;
    logic [SPI_BYTE_W-1:0] spi_data_in;
    logic                  spi_busy;
    logic [SPI_BYTE_W-1:0] spi_data_out;

    // master: the environment (host and SPI master core); slave: the sequencer.
    modport master (
        output tx_valid, tx_data, rx_ready, spi_busy, spi_data_out,
        input  tx_ready, rx_valid, rx_data, spi_start, spi_data_in
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready, spi_busy, spi_data_out,
        output tx_ready, rx_valid, rx_data, spi_start, spi_data_in
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous show-ahead FIFO with valid/ready on both sides and a level output.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_level != (AW+1)'(DEPTH));
    assign o_valid = (r_level != '0);
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;
    // Head is forced to zero while empty so the output is clean after reset.
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds queued host bytes to the SPI master one transaction at a time and
// collects the returned bytes, with credit-based RX overflow protection.
module spi_byte_sequencer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_byte_sequencer_if.slave  bus,
    output logic                 seq_idle,
    output logic                 err_timeout,
    output seq_state_e           o_dbg_state
);

    localparam int LW     = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = cnt_width(ACK_TIMEOUT);
    localparam int GAP_W  = cnt_width(GAP_CYCLES);

    seq_state_e            r_state;
    seq_state_e            w_next;

    logic                  w_tx_valid;
    logic [SPI_BYTE_W-1:0] w_tx_head;
    logic [LW-1:0]         w_tx_level;
    logic                  w_tx_pop;

    logic                  w_rx_space;
    logic                  w_rx_push;
    logic [LW-1:0]         w_rx_level;
    logic                  w_rx_latch;
    logic [SPI_BYTE_W-1:0] r_rx_byte;

    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic                  w_timeout;
    logic                  w_gap_done;
    logic                  w_set_err;
    logic                  w_in_flight;
    logic                  w_credit_ok;

    logic                  r_spi_start;
    logic [SPI_BYTE_W-1:0] r_spi_data_in;
    logic                  r_err;

    spi_sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.tx_valid),
        .o_ready (bus.tx_ready),
        .i_data  (bus.tx_data),
        .o_valid (w_tx_valid),
        .i_ready (w_tx_pop),
        .o_data  (w_tx_head),
        .o_level (w_tx_level)
    );

    spi_sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_rx_push),
        .o_ready (w_rx_space),
        .i_data  (r_rx_byte),
        .o_valid (bus.rx_valid),
        .i_ready (bus.rx_ready),
        .o_data  (bus.rx_data),
        .o_level (w_rx_level)
    );

    // A byte counts against RX space from the moment it is issued until captured.
    assign w_in_flight = (r_state == ISSUE) || (r_state == WAIT_BUSY) ||
                         (r_state == WAIT_DONE) || (r_state == CAPTURE);
    assign w_credit_ok = ({1'b0, w_rx_level} + (LW+1)'(w_in_flight)) < (LW+1)'(FIFO_DEPTH);
    assign w_timeout   = (r_wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));
    assign w_gap_done  = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_tx_valid && w_credit_ok && !bus.spi_busy) w_next = ISSUE;
            ISSUE:     w_next = WAIT_BUSY;
            WAIT_BUSY: if (bus.spi_busy) w_next = WAIT_DONE;
                       else if (w_timeout) w_next = GAP;
            WAIT_DONE: if (!bus.spi_busy) w_next = CAPTURE;
            CAPTURE:   w_next = GAP;
            GAP:       if (w_gap_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop   = (r_state == ISSUE);
        w_rx_latch = (r_state == WAIT_DONE) && !bus.spi_busy;
        w_rx_push  = (r_state == CAPTURE) && w_rx_space;
        w_set_err  = (r_state == WAIT_BUSY) && !bus.spi_busy && w_timeout;
    end

    // Start and data are registered off the next state so the pulse lands in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_start   <= 1'b0;
            r_spi_data_in <= '0;
            r_rx_byte     <= '0;
            r_wait_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_err         <= 1'b0;
        end else begin
            r_spi_start <= (w_next == ISSUE);
            if ((r_state == IDLE) && (w_next == ISSUE)) r_spi_data_in <= w_tx_head;
            if (w_rx_latch) r_rx_byte <= bus.spi_data_out;
            r_wait_cnt <= (r_state == WAIT_BUSY) ? r_wait_cnt + 1'b1 : '0;
            r_gap_cnt  <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
            if (w_set_err) r_err <= 1'b1;
        end
    end

    assign bus.spi_start   = r_spi_start;
    assign bus.spi_data_in = r_spi_data_in;
    assign err_timeout     = r_err;
    assign seq_idle        = (r_state == IDLE) && (w_tx_level == '0);
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a behavioural SPI master model and
// queue-based scoreboards for issued bytes and returned bytes.
module tb_spi_byte_sequencer;
    import spi_pkg::*;

    localparam int FIFO_DEPTH  = 8;
    localparam int GAP_CYCLES  = 2;
    localparam int ACK_TIMEOUT = 8;
    localparam int SL_ECHO     = 0;
    localparam int SL_FIXED    = 1;
    localparam int SL_NEVER    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seq_idle;
    logic       err_timeout;
    seq_state_e dbg_state;

    spi_byte_sequencer_if bus ();

    spi_byte_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .GAP_CYCLES  (GAP_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .seq_idle    (seq_idle),
        .err_timeout (err_timeout),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] start_q[$];
    int         start_cnt  = 0;
    int         last_start = -1;
    logic       prev_busy  = 1'b0;
    int         slave_mode = SL_ECHO;
    logic [7:0] fixed_resp = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- SPI master model ----------------
    int         sl_cnt = 0;
    logic [7:0] sl_resp = 8'h00;
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            bus.spi_busy = 1'b0;
            sl_cnt = 0;
        end else if (sl_cnt > 0) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                bus.spi_busy     = 1'b0;
                bus.spi_data_out = sl_resp;
            end
        end else if (bus.spi_start && slave_mode != SL_NEVER) begin
            bus.spi_busy = 1'b1;
            sl_cnt = 3;
            sl_resp = (slave_mode == SL_ECHO) ? bus.spi_data_in : fixed_resp;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.spi_start) begin
                start_cnt++;
                check("start_while_busy", 32'(prev_busy), 32'd0);
                if (start_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL start_unexpected: got data 0x%0h expected no start", bus.spi_data_in);
                end else begin
                    check("spi_data_in", 32'(bus.spi_data_in), 32'(start_q.pop_front()));
                end
                if (last_start >= 0)
                    check("start_gap", 32'((cyc - last_start - 1) >= GAP_CYCLES), 32'd1);
                last_start = cyc;
            end
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no byte", bus.rx_data);
                end else begin
                    check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
                end
            end
        end else begin
            last_start = -1;
        end
        prev_busy = bus.spi_busy;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic ok;
        bit   done = 0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        for (int k = 0; k < 300 && !done; k++) begin
            ok = bus.tx_ready;
            step(1);
            if (ok) done = 1;
        end
        bus.tx_valid = 1'b0;
        if (!done) check("push_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            if (dbg_state == IDLE && seq_idle && exp_q.size() == 0 && !bus.rx_valid) done = 1;
            else step(1);
        end
        check(name, 32'(done), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        bit found;
        rst_n            = 1'b0;
        bus.tx_valid     = 1'b0;
        bus.tx_data      = 8'h00;
        bus.rx_ready     = 1'b0;
        bus.spi_busy     = 1'b0;
        bus.spi_data_out = 8'h00;
        step(3);

        check("rst_tx_ready",    32'(bus.tx_ready),    32'd1);
        check("rst_rx_valid",    32'(bus.rx_valid),    32'd0);
        check("rst_rx_data",     32'(bus.rx_data),     32'h0);
        check("rst_spi_start",   32'(bus.spi_start),   32'd0);
        check("rst_spi_data_in", 32'(bus.spi_data_in), 32'h0);
        check("rst_seq_idle",    32'(seq_idle),        32'd1);
        check("rst_err_timeout", 32'(err_timeout),     32'd0);
        rst_n = 1'b1;
        step(2);

        // Single byte, fixed response 0x3C
        slave_mode = SL_FIXED;
        fixed_resp = 8'h3C;
        bus.rx_ready = 1'b1;
        s0 = start_cnt;
        start_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        push_byte(8'hA5);
        check("t1_start_idle_cycle", 32'(bus.spi_start), 32'd0);
        step(1);
        check("t1_start_issue_cycle", 32'(bus.spi_start), 32'd1);
        check("t1_data_in", 32'(bus.spi_data_in), 32'hA5);
        wait_done("t1_done");
        check("t1_seq_idle", 32'(seq_idle), 32'd1);
        check("t1_starts", 32'(start_cnt - s0), 32'd1);

        // Eight bytes back-to-back, echoed
        slave_mode = SL_ECHO;
        s0 = start_cnt;
        for (int i = 1; i <= 8; i++) begin
            start_q.push_back(8'(i));
            exp_q.push_back(8'(i));
            push_byte(8'(i));
        end
        wait_done("t2_done");
        check("t2_starts", 32'(start_cnt - s0), 32'd8);

        // RX blocked: only eight transfers fit, then fill TX to full
        bus.rx_ready = 1'b0;
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            start_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
            push_byte(8'(8'h10 + i));
        end
        step(150);
        check("t3_starts_blocked", 32'(start_cnt - s0), 32'd8);
        check("t3_rx_valid", 32'(bus.rx_valid), 32'd1);
        check("t3_seq_not_idle", 32'(seq_idle), 32'd0);
        check("t3_state_idle", 32'(dbg_state), 32'(IDLE));
        for (int i = 10; i < 16; i++) begin
            start_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
            push_byte(8'(8'h10 + i));
        end
        check("t3_tx_full", 32'(bus.tx_ready), 32'd0);

        // Push against a full TX FIFO: 0xEE must never be stored
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t6_tx_ready_low", 32'(bus.tx_ready), 32'd0);
        end
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b1;
        wait_done("t3_drain_done");
        check("t3_starts_total", 32'(start_cnt - s0), 32'd16);
        check("t3_tx_ready_back", 32'(bus.tx_ready), 32'd1);

        // Slave never answers: timeout, then sequencer keeps going
        slave_mode = SL_NEVER;
        s0 = start_cnt;
        start_q.push_back(8'h55);
        push_byte(8'h55);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (start_cnt > s0) found = 1;
            else step(1);
        end
        check("t4_start_seen", 32'(found), 32'd1);
        step(3);
        check("t4_err_not_yet", 32'(err_timeout), 32'd0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (err_timeout) found = 1;
            else step(1);
        end
        check("t4_err_set", 32'(err_timeout), 32'd1);
        check("t4_no_rx", 32'(bus.rx_valid), 32'd0);
        slave_mode = SL_ECHO;
        start_q.push_back(8'h66);
        exp_q.push_back(8'h66);
        push_byte(8'h66);
        wait_done("t4_next_done");
        check("t4_err_sticky", 32'(err_timeout), 32'd1);
        check("t4_starts", 32'(start_cnt - s0), 32'd2);

        // Reset while the master is busy
        start_q.push_back(8'h77);
        push_byte(8'h77);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (dbg_state == WAIT_DONE) found = 1;
            else step(1);
        end
        check("t5_reach_wait_done", 32'(found), 32'd1);
        rst_n = 1'b0;
        step(1);
        check("t5_tx_ready",    32'(bus.tx_ready),    32'd1);
        check("t5_rx_valid",    32'(bus.rx_valid),    32'd0);
        check("t5_rx_data",     32'(bus.rx_data),     32'h0);
        check("t5_spi_start",   32'(bus.spi_start),   32'd0);
        check("t5_spi_data_in", 32'(bus.spi_data_in), 32'h0);
        check("t5_seq_idle",    32'(seq_idle),        32'd1);
        check("t5_err_cleared", 32'(err_timeout),     32'd0);
        check("t5_state",       32'(dbg_state),       32'(IDLE));
        rst_n = 1'b1;
        step(20);
        check("t5_no_rx_after", 32'(bus.rx_valid), 32'd0);
        check("t5_idle_after",  32'(seq_idle),     32'd1);
        check("t5_start_q_empty", 32'(start_q.size()), 32'd0);
        check("t5_exp_q_empty",   32'(exp_q.size()),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
